// File: rtl/pc_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_pkg
// Shared definitions for the instruction-fetch front end: the fetch FSM
// state encoding, the post-reset fetch address, the sequential PC step and
// the instruction word width.
// ---------------------------------------------------------------------------
package pc_fetch_sequencer_pkg;

  // Fetch FSM states: IDLE (just out of reset), REQ (request on the bus),
  // WAIT (request accepted, awaiting data), HOLD (instruction held for decode)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Base of the text segment, where fetch starts after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0004_0000;

  // Byte distance between consecutive instruction words
  localparam int PC_STEP = 4;

  // Width of one instruction word
  localparam int INSTR_W = 32;

endpackage

// File: rtl/pc_fetch_sequencer_fetch_out_buffer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_fetch_out_buffer
// One-entry holding register between fetch and decode. Holds
// {pc, pc_plus4, instr} and a valid flag.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   load        in   capture load_pc/load_instr and raise valid
//   flush       in   drop the held entry (wins over load and drain)
//   drain       in   decode consumed the entry, lower valid
//   load_pc     in   PC of the instruction being captured
//   load_instr  in   instruction word being captured
//   valid       out  entry present
//   pc          out  PC of held instruction
//   pc_plus4    out  pc + 4 (wraps)
//   instr       out  held instruction word
// ---------------------------------------------------------------------------
module pc_fetch_sequencer_fetch_out_buffer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic               drain,
  input  logic [N-1:0]       load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [N-1:0]       pc,
  output logic [N-1:0]       pc_plus4,
  output logic [INSTR_W-1:0] instr
);

  // Holding register. A flush only clears valid; the stale payload is
  // harmless because decode ignores it while valid is low. pc_plus4 is
  // computed once at load so decode sees a registered value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid    <= 1'b0;
      pc       <= '0;
      pc_plus4 <= '0;
      instr    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= load_pc;
      pc_plus4 <= load_pc + N'(PC_STEP);
      instr    <= load_instr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Instruction-fetch front end. Owns the fetch PC, issues one word read at a
// time to instruction memory, captures the returned word and presents
// {pc, pc+4, instr} to decode. Redirects from execute reload the fetch PC
// and squash whatever is in flight.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset           in   synchronous active-low reset
//   redirect_valid  in   branch/jump taken this cycle
//   redirect_pc     in   redirect target (low two bits forced to zero)
//   imem_req_valid  out  read request valid
//   imem_req_addr   out  read address, always the fetch PC
//   imem_req_ready  in   memory accepts request
//   imem_rsp_valid  in   read data valid, once per accepted request
//   imem_rsp_data   in   instruction word
//   if_valid        out  instruction available to decode
//   if_ready        in   decode accepts
//   if_pc           out  PC of presented instruction
//   if_pc_plus4     out  if_pc + 4
//   if_instr        out  presented instruction word
//   misaligned      out  one-cycle pulse when a redirect target was unaligned
// ---------------------------------------------------------------------------
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               imem_req_valid,
  output logic [N-1:0]       imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [N-1:0]       if_pc,
  output logic [N-1:0]       if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr,
  output logic               misaligned
);

  fetch_state_t state;
  logic [N-1:0] fetch_pc;
  logic         drop;
  logic [N-1:0] redirect_target;
  logic         buf_load;
  logic         buf_flush;
  logic         buf_drain;

  // Targets are word addresses; the low two bits are discarded and only
  // reported through the misaligned pulse.
  assign redirect_target = {redirect_pc[N-1:2], 2'b00};

  // The request is a pure decode of the state register, gated by reset so
  // nothing reaches memory while reset is held.
  assign imem_req_valid = reset && (state == WAIT_REQ_DUMMY_GUARD());
  assign imem_req_addr  = fetch_pc;

  // Buffer control. A response is captured only when it belongs to the
  // current fetch PC (drop clear) and no redirect is squashing it.
  assign buf_load  = (state == WAIT) && imem_rsp_valid && !drop && !redirect_valid;
  assign buf_flush = redirect_valid;
  assign buf_drain = (state == HOLD) && if_valid && if_ready;

  // Main fetch FSM. A redirect overrides every other event in the cycle:
  // the fetch PC is reloaded and any request already accepted at the old
  // address is marked with drop so its response is thrown away. Outside a
  // redirect the FSM walks REQ -> WAIT -> HOLD -> REQ, one request at a time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_req_ready) begin
              drop  <= 1'b1;
              state <= WAIT;
            end else begin
              state <= REQ;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              drop  <= 1'b1;
              state <= WAIT;
            end
          end
          HOLD:    state <= REQ;
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_req_ready) state <= WAIT;
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= REQ;
              end else begin
                fetch_pc <= fetch_pc + N'(PC_STEP);
                state    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (buf_drain) state <= REQ;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  pc_fetch_sequencer_fetch_out_buffer #(
    .N(N)
  ) u_out_buffer (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .flush     (buf_flush),
    .drain     (buf_drain),
    .load_pc   (fetch_pc),
    .load_instr(imem_rsp_data),
    .valid     (if_valid),
    .pc        (if_pc),
    .pc_plus4  (if_pc_plus4),
    .instr     (if_instr)
  );

  function automatic fetch_state_t WAIT_REQ_DUMMY_GUARD();
    return REQ;
  endfunction

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench for the fetch front end. A small instruction memory model
// answers accepted requests after a programmable delay. The stimulus process
// pushes the expected request addresses and decode entries into queues; a
// separate monitor pops and compares whenever the DUT issues an accepted
// request or completes a decode handshake.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misaligned;

  logic [31:0] req_q[$];
  out_t        out_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_delay = 0;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .if_instr      (if_instr),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  // Memory contents: the two program words at the text base, a tagged
  // pattern elsewhere so every address returns a distinct word.
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    if (addr == 32'h0004_0000) return 32'h2008_0005;
    if (addr == 32'h0004_0004) return 32'h2009_0003;
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got 0x%08h, expected nothing", name, actual);
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                               input logic req_ready, input logic ifr);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = req_ready;
    if_ready       = ifr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutDrain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (out_q.size() == 0) return;
    end
    reportFail({"timeout_", name}, 32'(out_q.size()));
  endtask

  task automatic waitIfValid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (if_valid) return;
    end
    reportFail({"timeout_", name}, 32'(if_valid));
  endtask

  // Memory model: latches an accepted request at the falling edge before
  // the accepting rising edge, then raises rsp_valid for one cycle after
  // rsp_delay extra cycles. It keeps counting through reset on purpose.
  initial begin : mem_model
    bit          pend;
    int          cnt;
    logic [31:0] pend_addr;
    pend = 1'b0;
    cnt  = 0;
    pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_data(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (reset && imem_req_valid && imem_req_ready && !pend) begin
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        cnt       = rsp_delay;
      end
    end
  end

  // Monitor: compares every accepted request against the request queue and
  // every decode handshake against the output queue; while decode stalls it
  // checks the presented entry stays put and no request is issued.
  initial begin : monitor
    logic [31:0] exp_addr;
    out_t        exp_out;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_req_valid && imem_req_ready) begin
          if (req_q.size() == 0) begin
            reportFail("req_unexpected", imem_req_addr);
          end else begin
            exp_addr = req_q.pop_front();
            checkOutput("req_addr", imem_req_addr, exp_addr);
          end
        end
        if (if_valid) begin
          checkOutput("hold_no_request", 32'(imem_req_valid), 32'h0);
          if (out_q.size() == 0) begin
            reportFail("if_unexpected", if_pc);
          end else if (if_ready) begin
            exp_out = out_q.pop_front();
            checkOutput("if_pc", if_pc, exp_out.pc);
            checkOutput("if_pc_plus4", if_pc_plus4, exp_out.pc4);
            checkOutput("if_instr", if_instr, exp_out.instr);
          end else begin
            exp_out = out_q[0];
            checkOutput("stall_pc", if_pc, exp_out.pc);
            checkOutput("stall_instr", if_instr, exp_out.instr);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();

    // Reset values
    checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_misaligned", 32'(misaligned), 32'h0);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);

    // Release: IDLE for one cycle, first request in the second cycle
    reset = 1'b1;
    checkOutput("rel_req_valid", 32'(imem_req_valid), 32'h0);
    step();
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0004_0000);

    // Zero-wait memory, decode always ready
    req_q.push_back(32'h0004_0000);
    req_q.push_back(32'h0004_0004);
    out_q.push_back('{32'h0004_0000, 32'h0004_0004, 32'h2008_0005});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    waitOutDrain("first_instr", 20);
    checkOutput("next_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("next_req_addr", imem_req_addr, 32'h0004_0004);

    // Decode stalls for five cycles on the second instruction
    out_q.push_back('{32'h0004_0004, 32'h0004_0008, 32'h2009_0003});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    waitIfValid("second_instr", 10);
    repeat (5) step();
    checkOutput("stall_if_valid", 32'(if_valid), 32'h1);
    checkOutput("stall_if_pc_plus4", if_pc_plus4, 32'h0004_0008);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'h0);
    req_q.push_back(32'h0004_0008);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    checkOutput("post_hs_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("post_hs_req_addr", imem_req_addr, 32'h0004_0008);
    checkOutput("post_hs_if_valid", 32'(if_valid), 32'h0);

    // Redirect coincident with acceptance of 0x40008
    req_q.push_back(32'h0004_0200);
    applyStimulus(1'b1, 32'h0004_0200, 1'b1, 1'b0);
    step();
    checkOutput("rdacc_misaligned", 32'(misaligned), 32'h0);
    checkOutput("rdacc_req_valid", 32'(imem_req_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    rsp_delay = 1;
    step();
    checkOutput("rdacc_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rdacc_new_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("rdacc_new_req_addr", imem_req_addr, 32'h0004_0200);

    // Redirect while waiting, response one cycle later
    step();
    checkOutput("rdwait_in_wait", 32'(imem_req_valid), 32'h0);
    req_q.push_back(32'h0004_0100);
    applyStimulus(1'b1, 32'h0004_0100, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    rsp_delay = 0;
    checkOutput("rdwait_still_wait", 32'(imem_req_valid), 32'h0);
    step();
    checkOutput("rdwait_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rdwait_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("rdwait_req_addr", imem_req_addr, 32'h0004_0100);

    // Misaligned redirect while holding 0x40100 for a stalled decode
    out_q.push_back('{32'h0004_0100, 32'h0004_0104, 32'hC0DE_0100});
    waitIfValid("redirect_target_instr", 10);
    rsp_delay = 2;
    req_q.push_back(32'h0004_0200);
    applyStimulus(1'b1, 32'h0004_0203, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("rdhold_if_valid", 32'(if_valid), 32'h0);
    checkOutput("rdhold_misaligned", 32'(misaligned), 32'h1);
    checkOutput("rdhold_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("rdhold_req_addr", imem_req_addr, 32'h0004_0200);
    void'(out_q.pop_front());
    step();
    checkOutput("rdhold_misaligned_end", 32'(misaligned), 32'h0);
    checkOutput("rdhold_in_wait", 32'(imem_req_valid), 32'h0);

    // Reset while waiting; the late response lands just after release
    reset = 1'b0;
    step();
    checkOutput("midrst_if_valid", 32'(if_valid), 32'h0);
    checkOutput("midrst_if_pc", if_pc, 32'h0);
    checkOutput("midrst_if_pc_plus4", if_pc_plus4, 32'h0);
    checkOutput("midrst_if_instr", if_instr, 32'h0);
    checkOutput("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    checkOutput("midrst_misaligned", 32'(misaligned), 32'h0);
    rsp_delay = 0;
    step();
    reset = 1'b1;
    req_q.push_back(32'h0004_0000);
    out_q.push_back('{32'h0004_0000, 32'h0004_0004, 32'h2008_0005});
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    checkOutput("restart_if_valid", 32'(if_valid), 32'h0);
    checkOutput("restart_req_valid", 32'(imem_req_valid), 32'h1);
    checkOutput("restart_req_addr", imem_req_addr, 32'h0004_0000);
    waitOutDrain("restart_instr", 20);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();

    checkOutput("req_q_empty", 32'(req_q.size()), 32'h0);
    checkOutput("out_q_empty", 32'(out_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Instruction-fetch front end that consumes the program counter. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, and captures the returned instruction. It presents {pc, pc+4, instr} to decode on a valid/ready channel. Branch/jump redirects from execute reload the fetch PC and squash in-flight work.

Parameters:
N, 32, address/PC width
RESET_PC, 32'h40000, fetch PC after reset (text segment base)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  N  redirect target
imem_req_valid  output  1  read request valid
imem_req_addr  output  N  read address (= fetch PC)
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  read data valid, exactly once per accepted request, ≥1 cycle after acceptance
imem_rsp_data  input  32  instruction word
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts
if_pc  output  N  PC of presented instruction
if_pc_plus4  output  N  if_pc + 4
if_instr  output  32  instruction word
misaligned  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (reset==0 at a clk edge) applies these values:
  - state=IDLE, fetch_pc=RESET_PC, drop=0, if_valid=0, if_pc=0, if_pc_plus4=0, if_instr=0, misaligned=0.
  - imem_req_valid=0 throughout reset.
- The reset operand is the only reset source; no asynchronous terms.
- FSM states: IDLE, REQ, WAIT, HOLD. imem_req_valid=1 only in REQ; imem_req_addr=fetch_pc always.
- IDLE -> REQ unconditionally. The first request appears in the second cycle after reset release.
- REQ: hold valid and address stable until imem_req_ready. Acceptance moves to WAIT.
- WAIT: imem_rsp_valid is sampled only in WAIT; responses in other states are ignored.
  - If drop=1: discard the response, clear drop, go to REQ.
  - Else: load the buffer (if_instr=rsp_data, if_pc=fetch_pc, if_pc_plus4=fetch_pc+4, if_valid=1), set fetch_pc=fetch_pc+4, go to HOLD.
- HOLD: if_valid && if_ready completes the handshake (if_valid=0 next cycle) and moves to REQ.
- Outputs in HOLD stay stable while if_ready=0.
- Only one request is outstanding at a time. Steady-state throughput is 1 instruction per 3 cycles with zero-wait memory and if_ready=1.
- Arithmetic: fetch_pc+4 wraps modulo 2^N; no overflow flag.
- Redirect (redirect_valid=1) has priority over all other events in the same cycle:
  - fetch_pc=redirect_pc with bits [1:0] forced to 0; misaligned pulses if they were nonzero.
  - IDLE/REQ without acceptance: go to REQ with the new address.
  - REQ with acceptance in the same cycle: the old-address request is outstanding; set drop=1, go to WAIT.
  - WAIT: set drop=1, stay in WAIT. If the response arrives in the same cycle, it is discarded and the FSM goes to REQ with drop=0.
  - HOLD: flush the buffer (if_valid=0 next cycle), go to REQ. A coincident if_valid&&if_ready counts as consumed, and the flush still applies.
- Reset mid-operation discards any outstanding memory response. Because the FSM restarts in IDLE/REQ, a late stale response is ignored.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, REQ, WAIT, HOLD)
  - RESET_PC default 32'h40000
  - PC_STEP = 4
  - INSTR_W = 32
- Natural sub-module: fetch_out_buffer. It is the one-entry valid/ready holding register for {pc, pc_plus4, instr}, with load, flush and drain inputs.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 at 0x40000, then 32'h2009_0003 at 0x40004, if_ready=1 -> first req in cycle 2 at addr 0x40000. if_valid presents pc=0x40000, pc_plus4=0x40004, instr=32'h2008_0005. Next req at 0x40004.
- if_ready held low 5 cycles after if_valid -> outputs stable, no new request issued. Request at the next address one cycle after the handshake.
- Redirect to 0x40100 in WAIT, response arrives next cycle -> response discarded, no if_valid. Next request addr 0x40100.
- Redirect to 0x40200 in the same cycle as REQ acceptance at 0x40008 -> drop set, stale response discarded. Request at 0x40200.
- Redirect to 0x40203 in HOLD -> if_valid drops next cycle, misaligned pulses 1 cycle, next request addr 0x40200.
- Reset asserted in WAIT with the response arriving 2 cycles later (reset still low / just released) -> response ignored, if_valid stays 0. Fetch restarts at 0x40000.
